asynchronous_fifo: RTL and testbench

//   First-in first-out buffer with a dual-pointer architecture.
//   - Stores DATA_WIDTH-bit words in a DEPTH-entry register array.
//   - Write side and read side run on one shared clock and one reset.
//   - Produces full/empty status so producers and consumers can throttle.
//   - Used as the generic elastic buffer between a producer and a consumer stage.

---
 rtl/asynchronous_fifo.sv | 58 +++++
 tb/tb_asynchronous_fifo.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/asynchronous_fifo.sv
// Single-clock FIFO with wrap-bit pointers; the extra pointer MSB separates full from empty.
// Read data is registered and holds its value whenever no read is accepted.
module asynchronous_fifo #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wptr;
  logic [AW:0]           rptr;
  logic                  wr_ok;
  logic                  rd_ok;

  // Both sides qualify against the flags as they stand before the edge.
  always_comb begin
    empty = (wptr == rptr);
    full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    wr_ok = w_en && !full;
    rd_ok = r_en && !empty;
  end

  // Storage carries no reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr[AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
    end else if (wr_ok) begin
      wptr <= wptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr     <= '0;
      data_out <= '0;
    end else if (rd_ok) begin
      data_out <= mem[rptr[AW-1:0]];
      rptr     <= rptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_asynchronous_fifo.sv
// Self-checking bench for asynchronous_fifo: directed scenarios plus a randomized
// run, all compared against a queue-based occupancy model.
module tb_asynchronous_fifo;

  localparam int DEPTH = 8;
  localparam int DW    = 8;

  logic          clk;
  logic          rst;
  logic          w_en;
  logic          r_en;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;

  int unsigned n_tests;
  int unsigned n_fail;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;

  asynchronous_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .w_en     (w_en),
    .r_en     (r_en),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of requests and advance the model using pre-edge occupancy.
  task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d);
    bit m_full;
    bit m_empty;
    w_en    = w;
    r_en    = r;
    data_in = d;
    @(posedge clk);
    m_full  = (q.size() == DEPTH);
    m_empty = (q.size() == 0);
    if (r && !m_empty) m_dout = q.pop_front();
    if (w && !m_full) q.push_back(d);
    #1;
    w_en = 1'b0;
    r_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; w_en = 1'b0; r_en = 1'b0; data_in = '0;
    q.delete();
    m_dout = '0;
    #20;
    n_tests++;
    if ({full, empty, data_out} !== {1'b0, 1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_state: full=%b empty=%b data_out=%0d, expected full=0 empty=1 data_out=0",
               full, empty, data_out);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b0, DW'(10 + i));
      n_tests++;
      if ({full, empty} !== {(i == DEPTH - 1), 1'b0}) begin
        n_fail++;
        $display("FAIL fill_flags[%0d]: full=%b empty=%b, expected full=%b empty=0",
                 i, full, empty, (i == DEPTH - 1));
      end
    end
  endtask

  task automatic test_overflow();
    cycle(1'b1, 1'b0, DW'(99));
    n_tests++;
    if ({full, empty, data_out} !== {1'b1, 1'b0, m_dout} || q.size() != DEPTH) begin
      n_fail++;
      $display("FAIL overflow: full=%b empty=%b data_out=%0d, expected full=1 empty=0 data_out=%0d",
               full, empty, data_out, m_dout);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, '0);
      n_tests++;
      if (data_out !== DW'(10 + i) || data_out !== m_dout) begin
        n_fail++;
        $display("FAIL drain_data[%0d]: data_out=%0d, expected %0d", i, data_out, 10 + i);
      end
    end
    n_tests++;
    if ({full, empty} !== 2'b01) begin
      n_fail++;
      $display("FAIL drain_empty: full=%b empty=%b, expected full=0 empty=1", full, empty);
    end
    cycle(1'b0, 1'b1, '0);
    n_tests++;
    if (data_out !== DW'(17) || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL read_on_empty: data_out=%0d empty=%b, expected data_out=17 empty=1",
               data_out, empty);
    end
  endtask

  task automatic test_simultaneous();
    cycle(1'b1, 1'b1, DW'(30));
    n_tests++;
    if ({empty, data_out} !== {1'b0, 8'd17}) begin
      n_fail++;
      $display("FAIL simul_first: empty=%b data_out=%0d, expected empty=0 data_out=17",
               empty, data_out);
    end
    cycle(1'b1, 1'b1, DW'(30));
    n_tests++;
    if ({empty, full, data_out} !== {1'b0, 1'b0, 8'd30} || q.size() != 1) begin
      n_fail++;
      $display("FAIL simul_second: empty=%b full=%b data_out=%0d, expected empty=0 full=0 data_out=30",
               empty, full, data_out);
    end
    cycle(1'b0, 1'b1, '0);
    n_tests++;
    if ({empty, data_out} !== {1'b1, 8'd30}) begin
      n_fail++;
      $display("FAIL simul_final: empty=%b data_out=%0d, expected empty=1 data_out=30",
               empty, data_out);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, DW'(40 + i));
    rst = 1'b1;
    q.delete();
    m_dout = '0;
    #1;
    n_tests++;
    if ({full, empty, data_out} !== {1'b0, 1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_mid: full=%b empty=%b data_out=%0d, expected full=0 empty=1 data_out=0",
               full, empty, data_out);
    end
    #2;
    rst = 1'b0;
    cycle(1'b1, 1'b0, 8'h5A);
    cycle(1'b0, 1'b1, '0);
    n_tests++;
    if ({empty, data_out} !== {1'b1, 8'h5A}) begin
      n_fail++;
      $display("FAIL reset_mid_rw: empty=%b data_out=%0h, expected empty=1 data_out=5a",
               empty, data_out);
    end
  endtask

  task automatic test_random();
    logic w;
    logic r;
    logic [DW-1:0] d;
    for (int i = 0; i < 400; i++) begin
      // Bias phases toward filling, then draining, so both boundaries are hit.
      if ((i / 50) % 2 == 0) begin
        w = ($urandom_range(0, 99) < 70);
        r = ($urandom_range(0, 99) < 35);
      end else begin
        w = ($urandom_range(0, 99) < 35);
        r = ($urandom_range(0, 99) < 70);
      end
      d = DW'($urandom);
      cycle(w, r, d);
      n_tests++;
      if ({full, empty, data_out} !== {(q.size() == DEPTH), (q.size() == 0), m_dout}) begin
        n_fail++;
        $display("FAIL random[%0d]: full=%b empty=%b data_out=%0h, expected full=%b empty=%b data_out=%0h",
                 i, full, empty, data_out, (q.size() == DEPTH), (q.size() == 0), m_dout);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
